video_testcard: RTL and testbench

//  Free-running PAL-style (312-line progressive, 50 Hz) composite test-card generator.

---
 rtl/video_testcard.sv | 122 ++++++++++++
 tb/tb_video_testcard.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/video_testcard.sv
// video_testcard: free-running 312-line progressive, 50 Hz composite test-card
// generator for a 12 MHz clock and a 2-bit resistor DAC (o_sync, o_white).
// Eight vertical bars alternating white/black across the active width.
// Optional build macro TESTCARD_GRID_EN: ORs a white horizontal grid line onto
// the bars on every 32nd active line, starting with the first active line.
module video_testcard (
  input  logic clk,
  input  logic rst,
  output logic o_sync,
  output logic o_white
);

  localparam logic [9:0] H_TOTAL      = 10'd768;
  localparam logic [9:0] H_SYNC       = 10'd56;
  localparam logic [9:0] H_ACT_START  = 10'd128;
  localparam logic [9:0] H_ACT_END    = 10'd736;
  localparam logic [8:0] V_TOTAL      = 9'd312;
  localparam logic [8:0] V_SYNC_LINES = 9'd3;
  localparam logic [8:0] V_ACT_START  = 9'd23;
  localparam logic [8:0] V_ACT_END    = 9'd310;
  localparam logic [6:0] BAR_WIDTH    = 7'd76;

  // Broad pulses are low for 711 clocks, leaving a 57-clock serration at the
  // end of each vsync line.
  localparam logic [9:0] H_BROAD_END  = H_TOTAL - H_SYNC - 10'd1;

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [8:0] v_cnt_q, v_cnt_d;
  logic [6:0] bar_pos_q, bar_pos_d;
  logic [2:0] bar_idx_q, bar_idx_d;
  logic       o_sync_q, o_sync_d;
  logic       o_white_q, o_white_d;
  logic       h_last;
  logic       grid_hit;

  // Line and frame counters: v advances (and wraps) on the h wrap edge.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    h_last  = (h_cnt_q == H_TOTAL - 10'd1);
    if (h_last) begin
      h_cnt_d = 10'd0;
      v_cnt_d = (v_cnt_q == V_TOTAL - 9'd1) ? 9'd0 : v_cnt_q + 9'd1;
    end
  end

  // Bar counter: reloaded so bar 0 / position 0 lines up with h == H_ACT_START;
  // steps to the next bar every BAR_WIDTH clocks instead of dividing h.
  always_comb begin
    bar_pos_d = bar_pos_q + 7'd1;
    bar_idx_d = bar_idx_q;
    if (h_cnt_q == H_ACT_START - 10'd1) begin
      bar_pos_d = 7'd0;
      bar_idx_d = 3'd0;
    end else if (bar_pos_q == BAR_WIDTH - 7'd1) begin
      bar_pos_d = 7'd0;
      bar_idx_d = bar_idx_q + 3'd1;
    end
  end

`ifdef TESTCARD_GRID_EN
  logic [4:0] grid_cnt_q, grid_cnt_d;

  // Grid line counter: zero on the first active line, wraps every 32 lines.
  always_comb begin
    grid_cnt_d = grid_cnt_q;
    if (h_last) begin
      grid_cnt_d = (v_cnt_d == V_ACT_START) ? 5'd0 : grid_cnt_q + 5'd1;
    end
    grid_hit = (grid_cnt_q == 5'd0);
  end

  // Grid line counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) grid_cnt_q <= 5'd0;
    else      grid_cnt_q <= grid_cnt_d;
  end
`else
  // Plain bars: no grid overlay.
  always_comb begin
    grid_hit = 1'b0;
  end
`endif

  // Output decode from the current (pre-increment) counters.
  always_comb begin
    logic active;
    active = (v_cnt_q >= V_ACT_START) && (v_cnt_q < V_ACT_END) &&
             (h_cnt_q >= H_ACT_START) && (h_cnt_q < H_ACT_END);
    if (v_cnt_q < V_SYNC_LINES) begin
      o_sync_d = (h_cnt_q >= H_BROAD_END);
    end else begin
      o_sync_d = (h_cnt_q >= H_SYNC);
    end
    o_white_d = active && (~bar_idx_q[0] || grid_hit);
  end

  // State and output registers; outputs lag the counters by one clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_q   <= 10'd0;
      v_cnt_q   <= 9'd0;
      bar_pos_q <= 7'd0;
      bar_idx_q <= 3'd0;
      o_sync_q  <= 1'b1;
      o_white_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      bar_pos_q <= bar_pos_d;
      bar_idx_q <= bar_idx_d;
      o_sync_q  <= o_sync_d;
      o_white_q <= o_white_d;
    end
  end

  assign o_sync  = o_sync_q;
  assign o_white = o_white_q;

endmodule

// File: tb/tb_video_testcard.sv
// tb_video_testcard: directed, table-driven bench for video_testcard.
// Covers reset hold, vsync broad pulses, normal hsync, blanking, bar pattern,
// the first active line (grid-aware) and an asynchronous mid-line reset.
`timescale 1ns/1ps
module tb_video_testcard;

  logic clk;
  logic rst;
  logic o_sync;
  logic o_white;

  video_testcard dut (
    .clk     (clk),
    .rst     (rst),
    .o_sync  (o_sync),
    .o_white (o_white)
  );

  initial clk = 1'b0;
  always #42 clk = ~clk;

  typedef struct {
    int    v;
    int    h;
    bit    sync;
    bit    white;
    string name;
  } vec_t;

  localparam int LINE = 768;

  int n_vec;
  int n_bad;

`ifdef TESTCARD_GRID_EN
  localparam bit GRID = 1'b1;
`else
  localparam bit GRID = 1'b0;
`endif

  task automatic check(input string name, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t vecs[$];
  int   low_cnt   [0:31];
  int   white_cnt [0:31];
  int   fall_cyc  [0:31];

  task automatic add(input int v, input int h, input bit s, input bit w, input string n);
    vec_t e;
    e.v = v; e.h = h; e.sync = s; e.white = w; e.name = n;
    vecs.push_back(e);
  endtask

  initial begin
    int vi;
    int stop_cyc;
    int h;
    int v;
    int bad_white;
    int blank_white;
    int low_run;
    bit prev_sync;

    n_vec = 0;
    n_bad = 0;
    rst   = 1'b0;

    // Expected samples, in time order (v, h, o_sync, o_white).
    add(0,   0,   1'b0, 1'b0, "vs0_start");
    add(0,   710, 1'b0, 1'b0, "vs0_last_low");
    add(0,   711, 1'b1, 1'b0, "vs0_first_high");
    add(0,   767, 1'b1, 1'b0, "vs0_end");
    add(2,   710, 1'b0, 1'b0, "vs2_last_low");
    add(2,   711, 1'b1, 1'b0, "vs2_first_high");
    add(3,   0,   1'b0, 1'b0, "hs3_start");
    add(3,   55,  1'b0, 1'b0, "hs3_last_low");
    add(3,   56,  1'b1, 1'b0, "hs3_first_high");
    add(22,  200, 1'b1, 1'b0, "blank_line22");
    add(23,  128, 1'b1, 1'b1, "line23_first_act");
    add(23,  210, 1'b1, GRID, "line23_bar1");
    add(23,  735, 1'b1, GRID, "line23_last_act");
    add(23,  736, 1'b1, 1'b0, "line23_after_act");
    add(24,  55,  1'b0, 1'b0, "line24_hsync");
    add(24,  127, 1'b1, 1'b0, "line24_pre_act");
    add(24,  128, 1'b1, 1'b1, "bar0_first");
    add(24,  203, 1'b1, 1'b1, "bar0_last");
    add(24,  204, 1'b1, 1'b0, "bar1_first");
    add(24,  279, 1'b1, 1'b0, "bar1_last");
    add(24,  280, 1'b1, 1'b1, "bar2_first");
    add(24,  355, 1'b1, 1'b1, "bar2_last");
    add(24,  356, 1'b1, 1'b0, "bar3_first");
    add(24,  659, 1'b1, 1'b1, "bar6_last");
    add(24,  660, 1'b1, 1'b0, "bar7_first");
    add(24,  735, 1'b1, 1'b0, "bar7_last");
    add(24,  736, 1'b1, 1'b0, "line24_after_act");
    add(30,  300, 1'b1, 1'b1, "line30_bar2");

    for (int i = 0; i < 32; i++) begin
      low_cnt[i]   = 0;
      white_cnt[i] = 0;
      fall_cyc[i]  = 0;
    end

    // Reset held for about 1 us: outputs stay at reset values.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("reset_hold_sync", int'(o_sync), 1);
      check("reset_hold_white", int'(o_white), 0);
    end
    rst = 1'b1;

    // Walk lines 0..30 from release, cycle k reflects h=k%768, v=k/768.
    vi        = 0;
    bad_white = 0;
    prev_sync = 1'b1;
    stop_cyc  = 30 * LINE + 300;
    for (int cyc = 0; cyc <= stop_cyc; cyc++) begin
      tick();
      h = cyc % LINE;
      v = cyc / LINE;
      if (o_sync !== 1'b1) low_cnt[v]++;
      if (o_white === 1'b1) white_cnt[v]++;
      if (o_white === 1'b1 && o_sync !== 1'b1) bad_white++;
      if (prev_sync && o_sync === 1'b0) fall_cyc[v] = cyc;
      prev_sync = (o_sync === 1'b1);
      if (vi < vecs.size() && vecs[vi].v == v && vecs[vi].h == h) begin
        check({vecs[vi].name, "_sync"}, int'(o_sync), int'(vecs[vi].sync));
        check({vecs[vi].name, "_white"}, int'(o_white), int'(vecs[vi].white));
        vi++;
      end
    end
    check("vectors_reached", vi, vecs.size());

    // Whole-line statistics.
    check("vs_line0_low", low_cnt[0], 711);
    check("vs_line1_low", low_cnt[1], 711);
    check("vs_line2_low", low_cnt[2], 711);
    check("line3_low", low_cnt[3], 56);
    check("line10_low", low_cnt[10], 56);
    check("line10_fall_spacing", fall_cyc[10] - fall_cyc[9], LINE);
    blank_white = 0;
    for (int i = 0; i < 23; i++) blank_white += white_cnt[i];
    check("blank_lines_white", blank_white, 0);
    check("line23_white_clks", white_cnt[23], GRID ? 608 : 304);
    check("line24_white_clks", white_cnt[24], 304);
    check("line29_white_clks", white_cnt[29], 304);
    check("white_during_sync", bad_white, 0);

    // Mid-line asynchronous reset while o_white is high.
    #10 rst = 1'b0;
    #1;
    check("async_rst_sync", int'(o_sync), 1);
    check("async_rst_white", int'(o_white), 0);
    #89;
    check("rst_held_sync", int'(o_sync), 1);
    check("rst_held_white", int'(o_white), 0);
    rst = 1'b1;

    // Timing restarts at h=0, v=0: broad pulse from the first edge.
    tick();
    check("restart_sync", int'(o_sync), 0);
    check("restart_white", int'(o_white), 0);
    low_run = 1;
    for (int cyc = 1; cyc < LINE; cyc++) begin
      tick();
      if (o_sync !== 1'b1) low_run++;
      if (cyc == 711) check("restart_serration", int'(o_sync), 1);
    end
    check("restart_line0_low", low_run, 711);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
